// File: rtl/dmx8_seq.sv
// dmx8_seq: serial-bit distributor to eight registered channels with an
// external-select mode and an auto-scan mode that snapshots whole frames.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   y          serial data bit
//   valid      qualifies y for capture on this edge
//   mode       0 = external select via {s2,s1,s0}, 1 = auto-scan via ch
//   s0,s1,s2   external channel select (mode=0 only)
//   a..h       registered channel outputs, channels 0..7
//   ch         auto-scan channel counter
//   frame      snapshot of last complete auto-scan frame (frame[0]=a)
//   frame_done one-cycle pulse when frame is updated
module dmx8_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       y,
    input  logic       valid,
    input  logic       mode,
    input  logic       s0,
    input  logic       s1,
    input  logic       s2,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h,
    output logic [2:0] ch,
    output logic [7:0] frame,
    output logic       frame_done
);

    logic [7:0] chan_q, chan_d;
    logic [2:0] ch_q, ch_d;
    logic [7:0] frame_q, frame_d;
    logic       done_q, done_d;
    logic [2:0] idx;

    always_comb begin
        chan_d  = chan_q;
        ch_d    = ch_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        idx     = mode ? ch_q : {s2, s1, s0};

        if (valid) begin
            chan_d[idx] = y;
        end

        if (!mode) begin
            // Leaving auto-scan drops any partial frame.
            ch_d = 3'd0;
        end else if (valid) begin
            ch_d = ch_q + 3'd1;
            if (ch_q == 3'd7) begin
                // Channels 0..6 already hold this frame; bit 7 is arriving now.
                frame_d = {y, chan_q[6:0]};
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chan_q  <= 8'h00;
            ch_q    <= 3'd0;
            frame_q <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            chan_q  <= chan_d;
            ch_q    <= ch_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    assign a          = chan_q[0];
    assign b          = chan_q[1];
    assign c          = chan_q[2];
    assign d          = chan_q[3];
    assign e          = chan_q[4];
    assign f          = chan_q[5];
    assign g          = chan_q[6];
    assign h          = chan_q[7];
    assign ch         = ch_q;
    assign frame      = frame_q;
    assign frame_done = done_q;

endmodule
